// File: rtl/ones_cnt_pkg.sv
// rtl/ones_cnt_pkg.sv - shared types and width helpers for the popcount frame path
package ones_cnt_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  function automatic int calc_cnt_w(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  function automatic int calc_sum_w(input int data_width, input int max_words);
    return calc_cnt_w(data_width) + $clog2(max_words);
  endfunction

  function automatic int calc_wc_w(input int max_words);
    return $clog2(max_words) + 1;
  endfunction

  // Out-of-range popcounts are clamped to the word width.
  function automatic int sat_cnt(input int cnt, input int data_width);
    return (cnt > data_width) ? data_width : cnt;
  endfunction

endpackage

// File: rtl/ones_count.sv
// rtl/ones_count.sv - combinational population count of one data word
module ones_count
  import ones_cnt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = calc_cnt_w(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CNT_W-1:0]      cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt = cnt + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/ones_frame_accum.sv
// rtl/ones_frame_accum.sv - per-frame popcount accumulator with sum, word count, max and threshold verdict
module ones_frame_accum
  import ones_cnt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 256,
  parameter int CNT_W      = calc_cnt_w(DATA_WIDTH),
  parameter int SUM_W      = calc_sum_w(DATA_WIDTH, MAX_WORDS),
  parameter int WC_W       = calc_wc_w(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             in_last,
  input  logic [SUM_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [WC_W-1:0]  out_words,
  output logic [CNT_W-1:0] out_max,
  output logic             out_over,
  output logic             out_err
);

  state_t state_q, state_d;

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [WC_W-1:0]  words_q, words_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             err_q, err_d;

  logic             accept;
  logic             room;
  logic             over_range;
  logic [CNT_W-1:0] cnt_c;

  assign accept     = in_valid && (state_q == S_ACC);
  assign room       = words_q < WC_W'(MAX_WORDS);
  assign over_range = in_cnt > CNT_W'(DATA_WIDTH);
  assign cnt_c      = CNT_W'(sat_cnt(int'(in_cnt), DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_ACC;
      S_ACC:   if (accept && in_last) state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_ACC;
      default: state_d = S_INIT;
    endcase
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    in_ready  = (state_q == S_ACC);
    out_valid = (state_q == S_HOLD);
  end

  // Beats past MAX_WORDS leave sum/words/max untouched but mark the frame bad.
  always_comb begin
    sum_d   = sum_q;
    words_d = words_q;
    max_d   = max_q;
    err_d   = err_q;
    if (accept) begin
      if (over_range) begin
        err_d = 1'b1;
      end
      if (room) begin
        sum_d   = sum_q + SUM_W'(cnt_c);
        words_d = words_q + WC_W'(1);
        if (cnt_c > max_q) begin
          max_d = cnt_c;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q     <= '0;
      words_q   <= '0;
      max_q     <= '0;
      err_q     <= 1'b0;
      out_sum   <= '0;
      out_words <= '0;
      out_max   <= '0;
      out_over  <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept && in_last) begin
      out_sum   <= sum_d;
      out_words <= words_d;
      out_max   <= max_d;
      out_err   <= err_d;
      out_over  <= (sum_d >= thresh);
      sum_q     <= '0;
      words_q   <= '0;
      max_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      words_q   <= words_d;
      max_q     <= max_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ones_frame_accum.sv
// tb/tb_ones_frame_accum.sv - self-checking bench for ones_frame_accum (MAX_WORDS 256 and 4 side by side)
module tb_ones_frame_accum;

  localparam int DW = 16;

  typedef struct {
    int sum;
    int words;
    int mx;
    int over;
    int err;
  } res_t;

  typedef struct {
    int              nb;
    logic [5:0][7:0] cnt;
    int              th;
    int              a_sum, a_words, a_max, a_over, a_err;
    int              b_sum, b_words, b_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [4:0]  drv_cnt = '0;
  logic [12:0] thresh = '0;
  logic        out_ready = 1'b0;
  logic        use_pc = 1'b0;
  logic [15:0] pc_data = '0;
  logic [4:0]  pc_cnt;
  logic [4:0]  in_cnt;

  logic        in_ready_a, out_valid_a, out_over_a, out_err_a;
  logic [12:0] out_sum_a;
  logic [8:0]  out_words_a;
  logic [4:0]  out_max_a;

  logic        in_ready_b, out_valid_b, out_over_b, out_err_b;
  logic [6:0]  out_sum_b;
  logic [2:0]  out_words_b;
  logic [4:0]  out_max_b;

  int   n_pass = 0;
  int   n_total = 0;
  int   beats_q[$];
  res_t exp_a, exp_b;
  vec_t tbl[6];

  always #5 clk = ~clk;

  assign in_cnt = use_pc ? pc_cnt : drv_cnt;

  ones_count #(.DATA_WIDTH(DW)) u_pc (
    .data (pc_data),
    .cnt  (pc_cnt)
  );

  ones_frame_accum #(.DATA_WIDTH(DW), .MAX_WORDS(256)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .thresh    (thresh),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_sum   (out_sum_a),
    .out_words (out_words_a),
    .out_max   (out_max_a),
    .out_over  (out_over_a),
    .out_err   (out_err_a)
  );

  ones_frame_accum #(.DATA_WIDTH(DW), .MAX_WORDS(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .thresh    (thresh[6:0]),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_sum   (out_sum_b),
    .out_words (out_words_b),
    .out_max   (out_max_b),
    .out_over  (out_over_b),
    .out_err   (out_err_b)
  );

  // Reference: evaluates a whole frame's beat list at once.
  function automatic res_t model(input int mw, input int th);
    res_t r;
    int   c;
    r = '{default: 0};
    for (int i = 0; i < beats_q.size(); i++) begin
      c = (beats_q[i] > DW) ? DW : beats_q[i];
      if (beats_q[i] > DW) r.err = 1;
      if (i < mw) begin
        r.sum   += c;
        r.words += 1;
        if (c > r.mx) r.mx = c;
      end else begin
        r.err = 1;
      end
    end
    r.over = (r.sum >= th) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst in_ready_a", in_ready_a, 0);
    chk("rst out_valid_a", out_valid_a, 0);
    chk("rst out_sum_a", out_sum_a, 0);
    chk("rst out_words_a", out_words_a, 0);
    chk("rst out_err_a", out_err_a, 0);
    chk("rst in_ready_b", in_ready_b, 0);
    chk("rst out_valid_b", out_valid_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready_a", in_ready_a, 1);
    chk("post-rst in_ready_b", in_ready_b, 1);
    beats_q.delete();
  endtask

  task automatic beat(input int cnt, input bit last, input int th);
    int waited = 0;
    drv_cnt  = 5'(cnt);
    in_last  = last;
    thresh   = 13'(th);
    in_valid = 1'b1;
    while (!in_ready_a && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_a) chk("in_ready timeout", 0, 1);
    @(posedge clk);
    beats_q.push_back(cnt);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last) begin
      exp_a = model(256, th);
      exp_b = model(4, th);
      beats_q.delete();
    end
  endtask

  task automatic check_frame(input string tag);
    @(negedge clk);
    chk({tag, " out_valid_a"}, out_valid_a, 1);
    chk({tag, " in_ready_a"}, in_ready_a, 0);
    chk({tag, " sum_a"}, out_sum_a, exp_a.sum);
    chk({tag, " words_a"}, out_words_a, exp_a.words);
    chk({tag, " max_a"}, out_max_a, exp_a.mx);
    chk({tag, " over_a"}, out_over_a, exp_a.over);
    chk({tag, " err_a"}, out_err_a, exp_a.err);
    chk({tag, " out_valid_b"}, out_valid_b, 1);
    chk({tag, " sum_b"}, out_sum_b, exp_b.sum);
    chk({tag, " words_b"}, out_words_b, exp_b.words);
    chk({tag, " max_b"}, out_max_b, exp_b.mx);
    chk({tag, " over_b"}, out_over_b, exp_b.over);
    chk({tag, " err_b"}, out_err_b, exp_b.err);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " ack in_ready"}, in_ready_a, 1);
    chk({tag, " ack out_valid"}, out_valid_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, 5, 7, 1, 7, 1, 0, 7, 1, 0};
    tbl[1] = '{4, {8'd0, 8'd0, 8'd9, 8'd0, 8'd16, 8'd3}, 30, 28, 4, 16, 0, 0, 28, 4, 0};
    tbl[2] = '{6, {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, 10, 12, 6, 2, 1, 0, 8, 4, 1};
    tbl[3] = '{2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1}, 0, 2, 2, 1, 1, 0, 2, 2, 0};
    tbl[4] = '{2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd20}, 17, 17, 2, 16, 1, 1, 17, 2, 1};
    tbl[5] = '{5, {8'd0, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4}, 0, 20, 5, 4, 1, 0, 16, 4, 1};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tbl[i].nb; j++) begin
        beat(int'(tbl[i].cnt[j]), j == tbl[i].nb - 1, tbl[i].th);
      end
      check_frame($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl sum_a", i), out_sum_a, tbl[i].a_sum);
      chk($sformatf("vec%0d tbl words_a", i), out_words_a, tbl[i].a_words);
      chk($sformatf("vec%0d tbl max_a", i), out_max_a, tbl[i].a_max);
      chk($sformatf("vec%0d tbl over_a", i), out_over_a, tbl[i].a_over);
      chk($sformatf("vec%0d tbl err_a", i), out_err_a, tbl[i].a_err);
      chk($sformatf("vec%0d tbl sum_b", i), out_sum_b, tbl[i].b_sum);
      chk($sformatf("vec%0d tbl words_b", i), out_words_b, tbl[i].b_words);
      chk($sformatf("vec%0d tbl err_b", i), out_err_b, tbl[i].b_err);
      if (i == 1) begin
        // Stall the sink while a beat is already offered upstream.
        drv_cnt  = 5'd5;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          @(negedge clk);
          chk("bp in_ready", in_ready_a, 0);
          chk("bp out_valid", out_valid_a, 1);
          chk("bp sum stable", out_sum_a, 28);
          chk("bp max stable", out_max_a, 16);
        end
        ack("bp");
        beat(5, 0, 0);
        beat(1, 1, 6);
        check_frame("bp next");
        chk("bp next sum", out_sum_a, 6);
        chk("bp next words", out_words_a, 2);
      end
      ack($sformatf("vec%0d", i));
    end

    beat(3, 0, 0);
    beat(5, 0, 0);
    do_reset();
    beat(4, 1, 2);
    check_frame("mid-rst");
    chk("mid-rst sum", out_sum_a, 4);
    chk("mid-rst words", out_words_a, 1);
    ack("mid-rst");

    begin
      int total = 0;
      int pc;
      use_pc = 1'b1;
      for (int w = 0; w < 10; w++) begin
        pc_data = 16'($urandom);
        pc = 0;
        for (int b = 0; b < 16; b++) pc += int'(pc_data[b]);
        total += pc;
        beat(pc, w == 9, 80);
      end
      use_pc = 1'b0;
      check_frame("e2e");
      chk("e2e sw sum", out_sum_a, total);
      chk("e2e words", out_words_a, 10);
      ack("e2e");
    end

    for (int f = 0; f < 25; f++) begin
      int nb;
      nb = $urandom_range(1, 7);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        beat($urandom_range(0, 19), j == nb - 1, $urandom_range(0, 100));
      end
      check_frame($sformatf("rnd%0d", f));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      ack($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ones_frame_accum.md
Name: ones_frame_accum

Overview:
- Downstream consumer of the combinational ones counter. Takes a stream of per-word popcounts, grouped into frames by a last flag.
- Per frame it accumulates the total set-bit count, the word count and the largest single-word count. It also gives a threshold verdict.
- Upstream side and result side use valid/ready handshakes, so the block can sit between the popcount stage and a stalling sink.

Parameters:
- DATA_WIDTH, 16, width of the word whose popcount is supplied. Legal count range is 0..DATA_WIDTH.
- MAX_WORDS, 256, maximum beats per frame (power of two, at least 2).
- CNT_W, $clog2(DATA_WIDTH)+1, derived, popcount width (5 at default).
- SUM_W, CNT_W+$clog2(MAX_WORDS), derived, accumulator width (13 at default).
- WC_W, $clog2(MAX_WORDS)+1, derived, word-counter width (9 at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  popcount beat valid.
- in_ready  out  1  block accepts a beat.
- in_cnt  in  CNT_W  popcount of one word.
- in_last  in  1  beat is the final beat of its frame.
- thresh  in  SUM_W  threshold, sampled on the accepted last beat.
- out_valid  out  1  frame result valid.
- out_ready  in  1  sink accepts the result.
- out_sum  out  SUM_W  total ones in the frame.
- out_words  out  WC_W  beats counted in the frame.
- out_max  out  CNT_W  largest in_cnt in the frame (after clamping).
- out_over  out  1  out_sum >= sampled thresh.
- out_err  out  1  frame had an over-length or out-of-range beat.

Behaviour:
- Reset: rst_n is sampled low on a rising clk edge.
  - state=S_INIT; in_ready=0, out_valid=0.
  - out_sum, out_words, out_max, out_over, out_err = 0; all accumulators = 0.
  - Reset overrides everything, including a partial frame or a held result. The in-flight frame is discarded.
- FSM states: S_INIT, S_ACC, S_HOLD.
  - S_INIT -> S_ACC unconditionally. in_ready rises on the first cycle after rst_n is seen high.
  - S_ACC: in_ready=1, out_valid=0. Each beat with in_valid=1 is accepted.
  - S_HOLD: in_ready=0, out_valid=1. Outputs are stable until out_ready=1, then -> S_ACC with all accumulators cleared.
  - in_ready is registered: it is a function of state only, never of out_ready.
- Accepted beat in S_ACC:
  - c = min(in_cnt, DATA_WIDTH). If in_cnt > DATA_WIDTH, set the sticky err.
  - If words < MAX_WORDS: sum += c; words += 1; max = max(max, c).
  - Otherwise (beat MAX_WORDS+1 onward): the beat is dropped from sum, words and max, and sticky err is set.
  - sum cannot overflow SUM_W by construction.
- Accepted beat with in_last=1 (the beat's own contribution is included):
  - Register out_sum, out_words, out_max, out_err.
  - out_over = (final sum >= thresh), using thresh as it is on that cycle.
  - Go to S_HOLD. out_valid=1 on the next cycle, so latency is 1 cycle from the last-beat handshake.
- Single-beat frame: last beat in the first beat is legal, words=1.
- Zero popcounts are legal; thresh=0 always gives out_over=1.
- Between frames there is a 1-cycle bubble: the cycle after the out handshake is S_ACC.
- Outputs are undefined-free: out_* hold their last registered value when out_valid=0.

Decomposition:
- Package ones_cnt_pkg:
  - state enum {S_INIT, S_ACC, S_HOLD};
  - localparam helpers for CNT_W/SUM_W/WC_W derivation;
  - clamp function sat_cnt(in_cnt, DATA_WIDTH).
- Single module; no sub-module required.
- The bench instantiates the upstream combinational ones counter ahead of ones_frame_accum for the end-to-end scenario.

Test Plan:
1. Reset, then a 1-beat frame with in_cnt=7, in_last=1, thresh=5 -> one cycle later out_valid=1, out_sum=7, out_words=1, out_max=7, out_over=1, out_err=0.
2. 4-beat frame with counts 3,16,0,9 and thresh=30, out_ready=1 -> out_sum=28, out_words=4, out_max=16, out_over=0. in_ready returns to 1 one cycle after the output handshake.
3. Backpressure: hold out_ready=0 for 5 cycles after frame 2 -> outputs stable and in_ready=0 throughout. A beat driven with in_valid=1 during S_HOLD is not accepted and is counted in the next frame.
4. MAX_WORDS=4, a 6-beat frame of count 2 each -> out_sum=8, out_words=4, out_max=2, out_err=1. The next clean frame shows out_err=0.
5. in_cnt=20 with DATA_WIDTH=16 in a 2-beat frame (20, 1) -> out_sum=17, out_max=16, out_err=1.
6. Reset mid-frame after 2 accepted beats, then a 1-beat frame with in_cnt=4 -> out_sum=4, out_words=1. Also an end-to-end run of 10 random 16-bit words through the ones counter -> out_sum equals the software popcount sum.
